// File: rtl/viterbi_acs4.sv
// Add-compare-select array for a 4-state (K=3, 7/5) Viterbi decoder.
// Registers survivor metrics, per-state decisions and the best state.
module viterbi_acs4 #(
    parameter int PMW     = 6,
    parameter int BMW     = 3,
    parameter int INIT_PM = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             start,
    input  logic [BMW-1:0]   bm00,
    input  logic [BMW-1:0]   bm01,
    input  logic [BMW-1:0]   bm10,
    input  logic [BMW-1:0]   bm11,
    output logic             out_valid,
    output logic [3:0]       dec,
    output logic [4*PMW-1:0] pm,
    output logic [1:0]       best_state,
    output logic             norm_evt
);

    localparam logic [PMW-1:0] INIT = PMW'(INIT_PM);
    localparam logic [PMW-1:0] ZERO = '0;

    logic [3:0][PMW-1:0] pm_q;
    logic [3:0][PMW-1:0] pred;
    logic [3:0][PMW-1:0] bm_even;
    logic [3:0][PMW-1:0] bm_odd;
    logic [3:0][PMW-1:0] c0;
    logic [3:0][PMW-1:0] c1;
    logic [3:0][PMW-1:0] sel;
    logic [3:0][PMW-1:0] nrm;
    logic [3:0]          take_odd;
    logic                all_msb;
    logic [1:0]          best;
    logic [1:0]          b01;
    logic [1:0]          b23;
    logic                out_valid_q;
    logic [3:0]          dec_q;
    logic [1:0]          best_q;
    logic                norm_q;

    function automatic logic [PMW-1:0] ext(input logic [BMW-1:0] b);
        return {{(PMW-BMW){1'b0}}, b};
    endfunction

    // Frame start replaces the stored metrics with the seed vector.
    always_comb begin
        pred = pm_q;
        if (start) begin
            pred = {INIT, INIT, INIT, ZERO};
        end
    end

    // Trellis labels: even predecessor / odd predecessor per next state.
    always_comb begin
        bm_even[0] = ext(bm00);
        bm_odd[0]  = ext(bm11);
        bm_even[1] = ext(bm10);
        bm_odd[1]  = ext(bm01);
        bm_even[2] = ext(bm11);
        bm_odd[2]  = ext(bm00);
        bm_even[3] = ext(bm01);
        bm_odd[3]  = ext(bm10);
    end

    for (genvar ns = 0; ns < 4; ns++) begin : g_acs
        localparam int P0 = 2 * (ns % 2);
        localparam int P1 = P0 + 1;
        assign c0[ns]       = pred[P0] + bm_even[ns];
        assign c1[ns]       = pred[P1] + bm_odd[ns];
        assign take_odd[ns] = c1[ns] < c0[ns];
        assign sel[ns]      = take_odd[ns] ? c1[ns] : c0[ns];
    end

    assign all_msb = sel[0][PMW-1] & sel[1][PMW-1]
                   & sel[2][PMW-1] & sel[3][PMW-1];

    always_comb begin
        nrm = sel;
        if (all_msb) begin
            for (int i = 0; i < 4; i++) begin
                nrm[i][PMW-1] = 1'b0;
            end
        end
    end

    // Two-level min tree; strict compares keep ties on the lower index.
    always_comb begin
        b01  = (nrm[1] < nrm[0]) ? 2'd1 : 2'd0;
        b23  = (nrm[3] < nrm[2]) ? 2'd3 : 2'd2;
        best = (nrm[b23] < nrm[b01]) ? b23 : b01;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pm_q        <= {INIT, INIT, INIT, ZERO};
            out_valid_q <= 1'b0;
            dec_q       <= 4'd0;
            best_q      <= 2'd0;
            norm_q      <= 1'b0;
        end else begin
            out_valid_q <= in_valid;
            if (in_valid) begin
                pm_q   <= nrm;
                dec_q  <= take_odd;
                best_q <= best;
                norm_q <= all_msb;
            end
        end
    end

    assign pm         = pm_q;
    assign out_valid  = out_valid_q;
    assign dec        = dec_q;
    assign best_state = best_q;
    assign norm_evt   = norm_q;

endmodule

// File: tb/tb_viterbi_acs4.sv
// Directed self-checking bench for viterbi_acs4.
// Expected metrics are hand-derived from the 7/5 trellis.
module tb_viterbi_acs4;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        start;
    logic [2:0]  bm00, bm01, bm10, bm11;
    logic        out_valid;
    logic [3:0]  dec;
    logic [23:0] pm;
    logic [1:0]  best_state;
    logic        norm_evt;

    int n_checks = 0;
    int n_fail   = 0;

    viterbi_acs4 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .start      (start),
        .bm00       (bm00),
        .bm01       (bm01),
        .bm10       (bm10),
        .bm11       (bm11),
        .out_valid  (out_valid),
        .dec        (dec),
        .pm         (pm),
        .best_state (best_state),
        .norm_evt   (norm_evt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] pk(input int a, input int b,
                                       input int c, input int d);
        return {6'(d), 6'(c), 6'(b), 6'(a)};
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic [2:0] b00, input logic [2:0] b01,
                        input logic [2:0] b10, input logic [2:0] b11,
                        input logic st);
        @(negedge clk);
        bm00 = b00;
        bm01 = b01;
        bm10 = b10;
        bm11 = b11;
        start = st;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        start = 1'b0;
        check("out_valid_step", 32'(out_valid), 32'd1);
    endtask

    task automatic idle(input logic st);
        @(negedge clk);
        in_valid = 1'b0;
        start = st;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("out_valid_idle", 32'(out_valid), 32'd0);
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_pm", 32'(pm), 32'(pk(0, 16, 16, 16)));
        check("rst_ovld", 32'(out_valid), 32'd0);
        check("rst_best", 32'(best_state), 32'd0);
        check("rst_dec", 32'(dec), 32'd0);
        check("rst_norm", 32'(norm_evt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        start = 1'b0;
        bm00 = '0;
        bm01 = '0;
        bm10 = '0;
        bm11 = '0;
        #23;
        check("por_pm", 32'(pm), 32'(pk(0, 16, 16, 16)));
        check("por_ovld", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single step from reset
        step(3'd0, 3'd1, 3'd1, 3'd2, 1'b0);
        check("s2_pm", 32'(pm), 32'(pk(0, 17, 2, 17)));
        check("s2_dec", 32'(dec), 32'b0000);
        check("s2_best", 32'(best_state), 32'd0);
        idle(1'b0);

        // Decision path
        async_reset();
        step(3'd2, 3'd1, 3'd1, 3'd0, 1'b0);
        check("dp1_pm", 32'(pm), 32'(pk(2, 17, 0, 17)));
        check("dp1_best", 32'(best_state), 32'd2);
        step(3'd0, 3'd1, 3'd1, 3'd2, 1'b0);
        check("dp2_pm", 32'(pm), 32'(pk(2, 1, 4, 1)));
        check("dp2_best", 32'(best_state), 32'd1);
        step(3'd0, 3'd1, 3'd1, 3'd2, 1'b0);
        check("dp3_pm", 32'(pm), 32'(pk(2, 2, 1, 2)));
        check("dp3_dec", 32'(dec), 32'b1110);
        check("dp3_best", 32'(best_state), 32'd2);

        // Gaps hold state; start without in_valid is ignored
        idle(1'b0);
        idle(1'b1);
        idle(1'b0);
        check("gap_pm", 32'(pm), 32'(pk(2, 2, 1, 2)));
        check("gap_dec", 32'(dec), 32'b1110);
        check("gap_best", 32'(best_state), 32'd2);
        step(3'd0, 3'd1, 3'd1, 3'd2, 1'b1);
        check("restart_pm", 32'(pm), 32'(pk(0, 17, 2, 17)));
        check("restart_dec", 32'(dec), 32'b0000);

        // Normalization
        async_reset();
        step(3'd7, 3'd7, 3'd7, 3'd7, 1'b0);
        check("n1_pm", 32'(pm), 32'(pk(7, 23, 7, 23)));
        check("n1_norm", 32'(norm_evt), 32'd0);
        step(3'd7, 3'd7, 3'd7, 3'd7, 1'b0);
        check("n2_pm", 32'(pm), 32'(pk(14, 14, 14, 14)));
        check("n2_norm", 32'(norm_evt), 32'd0);
        step(3'd7, 3'd7, 3'd7, 3'd7, 1'b0);
        check("n3_pm", 32'(pm), 32'(pk(21, 21, 21, 21)));
        check("n3_norm", 32'(norm_evt), 32'd0);
        step(3'd7, 3'd7, 3'd7, 3'd7, 1'b0);
        check("n4_pm", 32'(pm), 32'(pk(28, 28, 28, 28)));
        check("n4_norm", 32'(norm_evt), 32'd0);
        check("n4_dec", 32'(dec), 32'b0000);
        step(3'd7, 3'd7, 3'd7, 3'd7, 1'b0);
        check("n5_pm", 32'(pm), 32'(pk(3, 3, 3, 3)));
        check("n5_norm", 32'(norm_evt), 32'd1);
        check("n5_best", 32'(best_state), 32'd0);
        idle(1'b0);
        check("n5_hold_norm", 32'(norm_evt), 32'd1);

        // Reset mid-stream with an update in flight
        step(3'd7, 3'd7, 3'd7, 3'd7, 1'b0);
        @(negedge clk);
        bm00 = 3'd5;
        bm01 = 3'd5;
        bm10 = 3'd5;
        bm11 = 3'd5;
        in_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_pm", 32'(pm), 32'(pk(0, 16, 16, 16)));
        @(posedge clk);
        #1;
        check("mid_rst_ovld", 32'(out_valid), 32'd0);
        check("mid_rst_hold", 32'(pm), 32'(pk(0, 16, 16, 16)));
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
        step(3'd0, 3'd1, 3'd1, 3'd2, 1'b0);
        check("post_rst_pm", 32'(pm), 32'(pk(0, 17, 2, 17)));
        check("post_rst_dec", 32'(dec), 32'b0000);
        check("post_rst_best", 32'(best_state), 32'd0);
        idle(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/viterbi_acs4.md
# viterbi_acs4

Add-compare-select (ACS) array for the 4-state (K=3, rate-1/2, generators 7/5 octal) Viterbi decoder. It sits between the branch-metric unit, which feeds it, and the survivor/traceback memory, which consumes its output. For each valid symbol period it:
- adds branch metrics to the stored path metrics;
- compares the two candidates per state using the team's 6-bit compare semantics;
- selects the survivor, registers the new metrics and emits one decision bit per state.

It also normalizes the metrics to prevent overflow and reports the best (minimum-metric) state to seed traceback.

## Interface
- PMW, 6, path-metric width in bits.
- BMW, 3, branch-metric width in bits (unsigned, 0..7).
- INIT_PM, 16, initial metric for states 1..3 at reset and frame start. State 0 always starts at 0.

Ports:
- clk  input  1  rising-edge clock; the block has one clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  branch metrics valid this cycle.
- start  input  1  frame start, qualified by in_valid.
- bm00, bm01, bm10, bm11  input  BMW each  branch metric for received-symbol hypothesis {c0,c1}.
- out_valid  output  1  decisions and metrics updated (one pulse per accepted input).
- dec  output  4  decision per next-state ns; bit ns = 1 means the odd predecessor was selected.
- pm  output  4*PMW  registered path metrics, state 0 in the LSBs.
- best_state  output  2  index of the minimum registered metric.
- norm_evt  output  1  normalization applied on this update.

## Operation
- State encoding s = {s1,s0}, where s1 is the most recent input bit.
- Input u moves state s to ns = {u, s1}.
- The predecessors of ns are p0 = 2*ns[0] (even) and p1 = 2*ns[0]+1 (odd).
- Branch-metric selection per (ns, p0 / p1):
  - ns0: bm00 / bm11
  - ns1: bm10 / bm01
  - ns2: bm11 / bm00
  - ns3: bm01 / bm10
- Candidates: c0 = pm[p0] + bm, c1 = pm[p1] + bm, computed as PMW-bit unsigned values.
- With the defaults, no sum exceeds 63, so there is no wrap and no saturation.
- Select: if c1 < c0 (unsigned), choose c1 and set dec[ns] = 1. Otherwise choose c0 and set dec[ns] = 0. Ties select the even predecessor.
- Normalization: if all four selected metrics have bit PMW-1 set, clear that bit in all four before registering and set norm_evt = 1.
- best_state: minimum of the four post-normalization metrics; ties go to the lowest index.
- Frame start (start=1 with in_valid=1): the predecessor metrics used this cycle are {0, INIT_PM, INIT_PM, INIT_PM}, not the stored pm. The result is stored normally.
- start with in_valid=0 is ignored.
- in_valid=0: pm holds its value, and dec, best_state and norm_evt hold their last values.

## Timing
- Latency is 1 cycle. Inputs accepted on rising edge N appear as pm, dec, best_state and norm_evt after edge N, with out_valid=1 during cycle N+1.
- The block has no backpressure. It accepts one input per cycle and can run back-to-back at full rate.
- out_valid is 0 in any cycle following an edge where in_valid was 0.
- Reset (rst_n=0) takes effect immediately, independent of clk:
  - pm = {0, INIT_PM, INIT_PM, INIT_PM}
  - out_valid = 0, dec = 0, best_state = 0, norm_evt = 0
- Reset asserted mid-stream discards any in-flight update.
- The first edge after rst_n deasserts behaves exactly as a frame start.
- Simultaneous start and normalization: normalization is evaluated on the start-seeded results.

## Test plan
- Reset: assert rst_n=0 between edges.
  -> Outputs clear asynchronously; pm={0,16,16,16}, out_valid=0, best_state=0.
- From reset, one step with bm00=0, bm01=1, bm10=1, bm11=2.
  -> pm={0,17,2,17}, dec=0000 (ties at ns1 and ns3 pick even), best_state=0, out_valid pulses 1 cycle.
- Decision path: from reset, apply three steps.
  - Step 1, bm=(00:2, 01:1, 10:1, 11:0) -> pm=(2,17,0,17), best_state=2.
  - Step 2, bm=(0,1,1,2) -> pm=(2,1,4,1).
  - Step 3, bm=(0,1,1,2) -> pm=(2,2,1,2), dec=1110, best_state=2.
- Normalization: from reset, five steps with all bm=7.
  - Metrics go (7,23,7,23), then 14s, 21s, 28s.
  - Step 5 stores 3,3,3,3 with norm_evt=1; norm_evt=0 on all other steps.
- Gaps and restart:
  - Insert in_valid=0 cycles mid-stream -> pm holds, out_valid=0.
  - Then apply start=1 with bm=(0,1,1,2) -> pm={0,17,2,17}, regardless of prior metrics.
- Reset mid-stream during back-to-back valid inputs -> no out_valid on the next cycle.
  - The first post-reset step matches scenario 2.
